iomem_timer: RTL and testbench
==============================

Name: iomem_timer

Overview:
- Programmable down-counting timer peripheral on the SoC external iomem bus, downstream of the SoC top level.
- Decodes a 256-byte window, answers CPU loads/stores with a one-cycle registered handshake, and raises a level interrupt.
- The interrupt is wired to one of the SoC external irq inputs (irq_5 by default).

Parameters:
- BASE_ADDR, 32'h0300_0000, window base; bits [7:0] ignored.
- PRESCALE_W, 8, width of the CTRL prescale field (1..8).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- iomem_valid  input  1  bus request from SoC
- iomem_ready  output  1  single-cycle acknowledge
- iomem_wstrb  input  4  byte write strobes; 0 = read
- iomem_addr  input  32  byte address
- iomem_wdata  input  32  write data
- iomem_rdata  output  32  read data; zero whenever iomem_ready=0
- irq  output  1  level interrupt = pending & irq_en

Behaviour:
- One clock, clk. Reset is synchronous and active-high: on reset, all registers, iomem_ready, iomem_rdata and irq go to 0.

Address decode and handshake:
- sel = iomem_valid && iomem_addr[31:8]==BASE_ADDR[31:8]. Register index = iomem_addr[7:2].
- At the edge where sel && !iomem_ready:
  - iomem_ready <= 1 and iomem_rdata <= the register value.
  - A write commits at this same edge.
- At the next edge iomem_ready <= 0 and iomem_rdata <= 0, even if iomem_valid is still high. Latency is 1 cycle; there is never back-to-back ready.
- When sel=0, iomem_ready stays 0 and iomem_rdata stays 0 (required for OR-mux sharing).
- Unmapped offsets inside the window: read returns 0, write is ignored, ready is still given.

Registers:
- 0x00 CTRL, rw, byte strobes honoured:
  - bit0 EN
  - bit1 PERIODIC
  - bit2 IRQ_EN
  - bits[8+PRESCALE_W-1:8] PRESCALE
  - other bits read 0
- 0x04 LOAD, rw, byte strobes honoured. Any write to LOAD also copies the new full value into COUNT and clears the prescaler.
- 0x08 COUNT, ro, current count; writes ignored.
- 0x0C STATUS, bit0 PENDING. Write 1 to bit0 (wstrb[0] set) clears it; write 0 has no effect.

Counting:
- Prescaler pre: while EN, pre counts 0..PRESCALE. tick = EN && pre==PRESCALE, after which pre returns to 0. While EN=0, pre holds 0.
- A CTRL write with EN going 0->1 clears pre.
- On tick with COUNT!=0: COUNT <= COUNT-1.
- On tick with COUNT==0 (expiry): PENDING <= 1, then:
  - if PERIODIC: COUNT <= LOAD.
  - else: EN <= 0 and COUNT stays 0 (one-shot).
- Period: (LOAD+1)*(PRESCALE+1) cycles between expiries. LOAD=0 with PRESCALE=0 and PERIODIC set expires every cycle.
- irq is combinational from the registers: pending & irq_en. It asserts the cycle after the expiry edge.

Simultaneous events:
- Expiry and a STATUS W1C at the same edge: set wins, PENDING=1.
- Tick and a LOAD write at the same edge: the write wins, COUNT=new LOAD, pre=0.
- Expiry and a CTRL write at the same edge: CTRL write data wins for EN.

Reset mid-transaction: ready is cleared, no write commits, and the CPU retry is served normally after reset.

Test Plan:
- Reset with valid held high -> ready=0, rdata=0, irq=0; after reset is released, a read of 0x0300_0000 returns 0 with ready high exactly 1 cycle after valid, then low.
- Write LOAD=3, then CTRL=0x7 (EN|PERIODIC|IRQ_EN, PRESCALE=0) -> COUNT reads 3,2,1,0 on successive ticks; PENDING and irq set at the 4th tick after EN; COUNT reloads 3; period 4 cycles.
- CTRL=0x0000_0205 (EN|IRQ_EN, one-shot, PRESCALE=2), LOAD=1 -> expiry after 6 cycles; EN reads 0 afterwards; COUNT stays 0; no further expiries.
- Write STATUS=1 on the same edge as an expiry -> PENDING remains 1. Write STATUS=1 later -> irq drops the next cycle. Write STATUS=0 -> no change.
- Byte write LOAD with wstrb=4'b0010, wdata=0x0000_AB00 over LOAD=0x1111_1111 -> LOAD=0x1111_AB11 and COUNT=0x1111_AB11.
- Access 0x0300_0040 (unmapped) reads 0 with ready; access 0x0400_0000 gets no ready and rdata stays 0.

Source files
------------

// File: rtl/iomem_timer.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_timer
//  Description : Down-counting timer peripheral on the SoC iomem bus.
//                256-byte register window, one-cycle registered handshake,
//                level interrupt (pending & irq_en).
//  Revision    : 1.0 - initial release
// ============================================================================
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam logic [5:0] c_idx_ctrl   = 6'd0;
  localparam logic [5:0] c_idx_load   = 6'd1;
  localparam logic [5:0] c_idx_count  = 6'd2;
  localparam logic [5:0] c_idx_status = 6'd3;

  // Bus handshake registers
  logic                  r_ready;
  logic [31:0]           r_rdata;
  // Timer state
  logic                  r_en;
  logic                  r_periodic;
  logic                  r_irq_en;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [31:0]           r_load;
  logic [31:0]           r_count;
  logic [PRESCALE_W-1:0] r_pre;
  logic                  r_pending;

  logic                  w_sel;
  logic                  w_acc;
  logic                  w_wr;
  logic [5:0]            w_idx;
  logic                  w_wr_ctrl;
  logic                  w_wr_load;
  logic                  w_clr_pending;
  logic [31:0]           w_ctrl_rd;
  logic [31:0]           w_ctrl_new;
  logic [31:0]           w_load_new;
  logic [31:0]           w_rd_val;
  logic                  w_tick;
  logic                  w_expire;
  logic                  w_en_next;
  logic                  w_unused;

  // Byte-lane merge of write data over an existing register value
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] m;
    m = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
    end
    return m;
  endfunction

  assign w_sel  = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  // An access is served only when ready is low, so ready never stays high two cycles
  assign w_acc  = w_sel && !r_ready;
  assign w_wr   = w_acc && (iomem_wstrb != 4'b0000);
  assign w_idx  = iomem_addr[7:2];

  assign w_wr_ctrl     = w_wr && (w_idx == c_idx_ctrl);
  assign w_wr_load     = w_wr && (w_idx == c_idx_load);
  assign w_clr_pending = w_wr && (w_idx == c_idx_status) && iomem_wstrb[0] && iomem_wdata[0];

  assign w_ctrl_new = f_merge(w_ctrl_rd, iomem_wdata, iomem_wstrb);
  assign w_load_new = f_merge(r_load, iomem_wdata, iomem_wstrb);

  assign w_tick   = r_en && (r_pre == r_prescale);
  assign w_expire = w_tick && (r_count == 32'd0);

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_pending & r_irq_en;

  assign w_unused = &{1'b0, iomem_addr[1:0], w_ctrl_new[31:8+PRESCALE_W], w_ctrl_new[7:3]};

  // CTRL register image as seen by the CPU; undefined bits read zero
  always_comb begin
    w_ctrl_rd                   = 32'd0;
    w_ctrl_rd[2:0]              = {r_irq_en, r_periodic, r_en};
    w_ctrl_rd[8 +: PRESCALE_W]  = r_prescale;
  end

  // Read data mux; unmapped offsets return zero
  always_comb begin
    w_rd_val = 32'd0;
    case (w_idx)
      c_idx_ctrl:   w_rd_val = w_ctrl_rd;
      c_idx_load:   w_rd_val = r_load;
      c_idx_count:  w_rd_val = r_count;
      c_idx_status: w_rd_val = {31'd0, r_pending};
      default:      w_rd_val = 32'd0;
    endcase
  end

  // Next EN: one-shot expiry clears it, but a CTRL write at the same edge wins
  always_comb begin
    w_en_next = r_en;
    if (w_expire && !r_periodic) w_en_next = 1'b0;
    if (w_wr_ctrl)               w_en_next = w_ctrl_new[0];
  end

  // Bus handshake: one-cycle ready pulse with registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else if (w_acc) begin
      r_ready <= 1'b1;
      r_rdata <= w_rd_val;
    end else begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end
  end

  // Control and load registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= '0;
      r_load     <= 32'd0;
    end else begin
      r_en <= w_en_next;
      if (w_wr_ctrl) begin
        r_periodic <= w_ctrl_new[1];
        r_irq_en   <= w_ctrl_new[2];
        r_prescale <= w_ctrl_new[8 +: PRESCALE_W];
      end
      if (w_wr_load) r_load <= w_load_new;
    end
  end

  // Prescaler: free-runs 0..PRESCALE while enabled, held at 0 otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
    end else if (w_wr_load || !w_en_next || !r_en || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRESCALE_W'(1);
    end
  end

  // Down counter: a LOAD write overrides a coincident tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 32'd0;
    end else if (w_wr_load) begin
      r_count <= w_load_new;
    end else if (w_tick) begin
      if (r_count != 32'd0) r_count <= r_count - 32'd1;
      else if (r_periodic)  r_count <= r_load;
      else                  r_count <= 32'd0;
    end
  end

  // Pending flag: expiry set has priority over write-one-to-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (w_expire) begin
      r_pending <= 1'b1;
    end else if (w_clr_pending) begin
      r_pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iomem_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iomem_timer
//  Description : Self-checking bench for iomem_timer. Expected read data is
//                queued when an access is issued and compared when ready
//                is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_timer;

  localparam logic [31:0] c_base   = 32'h0300_0000;
  localparam logic [31:0] c_ctrl   = c_base + 32'h0;
  localparam logic [31:0] c_load   = c_base + 32'h4;
  localparam logic [31:0] c_count  = c_base + 32'h8;
  localparam logic [31:0] c_status = c_base + 32'hC;

  logic        clk;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq;

  int          n_checks;
  int          n_pass;
  logic [31:0] sb_q[$];

  iomem_timer #(
    .BASE_ADDR  (c_base),
    .PRESCALE_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq         (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One bus access; ready is expected exactly one edge after valid, then low again.
  // Reads push their expectation, which is popped when ready is seen.
  task automatic acc(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     input logic [31:0] e, input string tag);
    logic [31:0] exp_v;
    if (s == 4'b0000) sb_q.push_back(e);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    @(posedge clk); #1;
    check({tag, "_rdy"}, 32'(iomem_ready), 32'd1);
    if (s == 4'b0000 && sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      check(tag, iomem_rdata, exp_v);
    end
    iomem_valid = 1'b0;
    iomem_addr  = 32'd0;
    iomem_wstrb = 4'd0;
    iomem_wdata = 32'd0;
    @(posedge clk); #1;
    check({tag, "_drop"}, 32'(iomem_ready), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input string tag);
    acc(a, s, d, 32'd0, tag);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    acc(a, 4'b0000, 32'd0, e, tag);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_v;
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b1;
    iomem_valid = 1'b1;
    iomem_addr  = c_base;
    iomem_wstrb = 4'd0;
    iomem_wdata = 32'd0;

    // Reset with valid held high
    cycles(3);
    check("rst_ready", 32'(iomem_ready), 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(32'd0);
    @(posedge clk); #1;
    check("lat1_ready", 32'(iomem_ready), 32'd1);
    if (iomem_ready) begin
      exp_v = sb_q.pop_front();
      check("lat1_rdata", iomem_rdata, exp_v);
    end
    @(posedge clk); #1;
    check("no_b2b_ready", 32'(iomem_ready), 32'd0);
    check("no_b2b_rdata", iomem_rdata, 32'd0);
    iomem_valid = 1'b0;
    sb_q.delete();
    cycles(2);

    // Periodic, LOAD=3, PRESCALE=0: expiries every 4 cycles after EN edge B
    wr(c_load, 4'hF, 32'd3, "p_load");
    rd(c_count, 32'd3, "p_count_init");
    wr(c_ctrl, 4'hF, 32'h7, "p_ctrl");             // commit at B
    check("p_irq_b1", 32'(irq), 32'd0);
    cycles(2);
    check("p_irq_b3", 32'(irq), 32'd0);
    cycles(1);
    check("p_irq_b4", 32'(irq), 32'd1);
    rd(c_count, 32'd3, "p_count_reload");           // value after B+4
    rd(c_count, 32'd1, "p_count_b6");               // value after B+6
    rd(c_status, 32'd1, "p_status");
    wr(c_status, 4'b0001, 32'd1, "p_w1c_a");        // B+11, re-expiry at B+12
    check("p_irq_period", 32'(irq), 32'd1);
    cycles(3);
    wr(c_status, 4'b0001, 32'd1, "p_w1c_same");     // same edge as expiry B+16
    check("p_set_wins", 32'(irq), 32'd1);
    wr(c_status, 4'b0001, 32'd1, "p_w1c_b");        // B+18
    check("p_irq_clr", 32'(irq), 32'd0);
    cycles(2);
    wr(c_status, 4'b0001, 32'd0, "p_w0");           // B+22, pending from B+20
    check("p_w0_noop", 32'(irq), 32'd1);
    wr(c_ctrl, 4'hF, 32'd0, "p_stop");
    wr(c_status, 4'b0001, 32'd1, "p_w1c_c");
    check("p_irq_off", 32'(irq), 32'd0);
    rd(c_status, 32'd0, "p_status_clr");

    // One-shot, LOAD=1, PRESCALE=2: expiry 6 cycles after EN edge Q
    wr(c_load, 4'hF, 32'd1, "o_load");
    wr(c_ctrl, 4'hF, 32'h0000_0205, "o_ctrl");       // commit at Q
    cycles(4);
    check("o_irq_q5", 32'(irq), 32'd0);
    cycles(1);
    check("o_irq_q6", 32'(irq), 32'd1);
    rd(c_ctrl, 32'h0000_0204, "o_ctrl_en_off");
    rd(c_count, 32'd0, "o_count_zero");
    wr(c_status, 4'b0001, 32'd1, "o_w1c");
    cycles(20);
    check("o_no_reexp", 32'(irq), 32'd0);
    rd(c_status, 32'd0, "o_status");
    rd(c_count, 32'd0, "o_count_hold");

    // Byte strobes on LOAD and CTRL
    wr(c_load, 4'hF, 32'h1111_1111, "b_load_full");
    wr(c_load, 4'b0010, 32'h0000_AB00, "b_load_byte");
    rd(c_load, 32'h1111_AB11, "b_load_rd");
    rd(c_count, 32'h1111_AB11, "b_count_rd");
    wr(c_ctrl, 4'hF, 32'hFFFF_FF00, "b_ctrl_ones");
    rd(c_ctrl, 32'h0000_FF00, "b_ctrl_rd");
    wr(c_ctrl, 4'hF, 32'd0, "b_ctrl_zero");

    // LOAD=0, PRESCALE=0, periodic: expires every cycle; irq masked by IRQ_EN=0
    wr(c_load, 4'hF, 32'd0, "e_load");
    wr(c_ctrl, 4'hF, 32'h3, "e_ctrl");
    wr(c_status, 4'b0001, 32'd1, "e_w1c");
    rd(c_status, 32'd1, "e_status");
    check("e_irq_masked", 32'(irq), 32'd0);
    rd(c_count, 32'd0, "e_count");
    wr(c_ctrl, 4'hF, 32'd0, "e_stop");
    wr(c_status, 4'b0001, 32'd1, "e_w1c2");
    rd(c_status, 32'd0, "e_status_clr");

    // Unmapped offset inside the window, then an address outside it
    rd(c_base + 32'h40, 32'd0, "w_unmapped");
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("w_out_ready", 32'(iomem_ready), 32'd0);
      check("w_out_rdata", iomem_rdata, 32'd0);
    end
    iomem_valid = 1'b0;
    iomem_addr  = 32'd0;

    // Reset mid-transaction, retry served afterwards
    @(negedge clk);
    reset       = 1'b1;
    iomem_valid = 1'b1;
    iomem_addr  = c_load;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    check("r_ready_rst", 32'(iomem_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("r_retry_ready", 32'(iomem_ready), 32'd1);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'd0;
    iomem_wdata = 32'd0;
    cycles(1);
    rd(c_load, 32'h0000_0055, "r_load_rd");
    rd(c_count, 32'h0000_0055, "r_count_rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
